// File: rtl/vin_timing_monitor.sv
// Video input timing monitor: measures hs/vs/de line and frame timing and locks after
// LOCK_FRAMES conforming frames. Define VIN_MON_STATS_EN to build the measurement outputs.
module vin_timing_monitor #(
  parameter int H_WIDTH     = 1920,
  parameter int H_TOTAL     = 2200,
  parameter int V_HEIGHT    = 1080,
  parameter int LOCK_FRAMES = 4,
  parameter int CW          = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          de_i,
  output logic          locked_o,
  output logic          frame_start_o,
  output logic [7:0]    err_count_o,
  output logic [CW-1:0] h_active_o,
  output logic [CW-1:0] h_total_o,
  output logic [CW-1:0] v_active_o
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] H_WIDTH_C  = CW'(H_WIDTH);
  localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_HEIGHT_C = CW'(V_HEIGHT);
  localparam logic [3:0]    LOCK_C     = 4'(LOCK_FRAMES);

  logic hs_r, vs_r, de_r, hs_p, vs_p, de_p;
  logic hs_rise, vs_rise, de_rise, de_fall;
  logic [CW-1:0] h_cnt, de_cnt, v_cnt;
  logic bad, bad_next, line_valid, timeout, frame_ok;
  state_t state, state_next;
  logic [3:0] good_cnt, good_next;
  logic err_inc, locked_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      {hs_r, vs_r, de_r} <= '0;
      {hs_p, vs_p, de_p} <= '0;
    end else begin
      {hs_r, vs_r, de_r} <= {hs_i, vs_i, de_i};
      {hs_p, vs_p, de_p} <= {hs_r, vs_r, de_r};
    end
  end

  assign hs_rise = hs_r & ~hs_p;
  assign vs_rise = vs_r & ~vs_p;
  assign de_rise = de_r & ~de_p;
  assign de_fall = ~de_r & de_p;

  // A saturated line counter means hs has vanished for longer than any legal line.
  assign timeout  = (h_cnt == CNT_MAX);
  assign bad_next = bad
                  | (hs_rise & line_valid & (h_cnt != H_TOTAL_C))
                  | (de_fall & (de_cnt != H_WIDTH_C));
  assign frame_ok = ~bad_next & (v_cnt == V_HEIGHT_C);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt      <= '0;
      de_cnt     <= '0;
      v_cnt      <= '0;
      bad        <= 1'b0;
      line_valid <= 1'b0;
    end else begin
      if (hs_rise)        h_cnt <= CW'(1);
      else if (!timeout)  h_cnt <= h_cnt + 1'b1;

      if (de_rise)                         de_cnt <= CW'(1);
      else if (de_r && de_cnt != CNT_MAX)  de_cnt <= de_cnt + 1'b1;

      if (vs_rise)                           v_cnt <= '0;
      else if (de_rise && v_cnt != CNT_MAX)  v_cnt <= v_cnt + 1'b1;

      bad <= vs_rise ? 1'b0 : bad_next;

      if (timeout)                          line_valid <= 1'b0;
      else if (hs_rise && state != SEARCH)  line_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    unique case (state)
      SEARCH: if (vs_rise) begin
        state_next = CHECK;
        good_next  = '0;
      end
      CHECK: if (vs_rise) begin
        if (frame_ok) begin
          if (good_cnt != 4'hF) good_next = good_cnt + 1'b1;
          if (good_cnt + 4'd1 == LOCK_C) state_next = LOCKED;
        end else begin
          good_next = '0;
        end
      end
      LOCKED: if (vs_rise && !frame_ok) begin
        state_next = CHECK;
        good_next  = '0;
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
    // Loss of hs overrides any same-cycle frame decision.
    if (timeout) begin
      state_next = SEARCH;
      good_next  = '0;
    end
  end

  always_comb begin
    locked_d = (state == LOCKED);
    err_inc  = (state == LOCKED) && (timeout || (vs_rise && !frame_ok));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_o    <= 1'b0;
      err_count_o <= '0;
    end else begin
      locked_o <= locked_d;
      if (err_inc && err_count_o != 8'hFF) err_count_o <= err_count_o + 1'b1;
    end
  end

  assign frame_start_o = vs_rise;

`ifdef VIN_MON_STATS_EN
  logic [CW-1:0] de_last, h_last;

  // Measurements landing on the vs rise cycle itself are forwarded into the snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_last    <= '0;
      h_last     <= '0;
      h_active_o <= '0;
      h_total_o  <= '0;
      v_active_o <= '0;
    end else begin
      if (de_fall) de_last <= de_cnt;
      if (hs_rise) h_last  <= h_cnt;
      if (vs_rise) begin
        h_active_o <= de_fall ? de_cnt : de_last;
        h_total_o  <= hs_rise ? h_cnt : h_last;
        v_active_o <= v_cnt;
      end
    end
  end
`else
  assign h_active_o = '0;
  assign h_total_o  = '0;
  assign v_active_o = '0;
`endif

endmodule
